// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : riscv_pkg                                                       |
// | Purpose  : Shared constants and types for the RISC-V core front end:       |
// |            datapath width, bubble instruction, major opcodes used by       |
// |            ImmGen/decode, and the fetch-stage state encoding.              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package riscv_pkg;

  localparam int          XLEN      = 64;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  // FETCH: request outstanding at pc
  // DROP : request outstanding but its data is stale (redirect arrived before ack)
  // HOLD : fetched word parked because IF/ID could not take it
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : if_id_reg                                                       |
// | Purpose  : IF/ID pipeline register holding valid/pc/instr. Priority is     |
// |            flush > load > hold > clear. When not valid, instr always       |
// |            carries the bubble so decode/ImmGen see a harmless NOP.         |
// | Ports    : clk, rst           clock, synchronous active-high reset         |
// |            flush, load, hold  update controls                              |
// |            load_pc/load_instr entry written on load                        |
// |            valid/pc/instr     register contents                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module if_id_reg #(
  parameter int          XLEN      = riscv_pkg::XLEN,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            load,
  input  logic            hold,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= '0;
      instr <= NOP_INSTR;
    end else if (flush) begin
      // pc is left as-is: it is meaningless while valid=0
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else if (!hold) begin
      // entry consumed (or already empty) and nothing new arrives
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fetch_stage                                                     |
// | Purpose  : Instruction fetch. Owns the PC, runs a single-outstanding       |
// |            req/ack handshake to instruction memory and fills the IF/ID     |
// |            register. Honours stall and branch redirect from downstream.    |
// |            One instruction per cycle when memory acks every cycle.         |
// | Ports    : clk, rst                 clock, synchronous active-high reset   |
// |            stall                    IF/ID not consumed this cycle          |
// |            redirect, redirect_pc    flush and refetch from target          |
// |            imem_req/addr/ack/rdata  instruction memory handshake           |
// |            if_id_valid/pc/instr     IF/ID register outputs                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_stage #(
  parameter int              XLEN      = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr
);

  import riscv_pkg::*;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};
  localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'd4};

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] redir_pc, redir_pc_nxt;
  logic [XLEN-1:0] hold_pc, hold_pc_nxt;
  logic [31:0]     hold_instr, hold_instr_nxt;

  logic            accept;
  logic [XLEN-1:0] target;
  logic            load;
  logic [XLEN-1:0] load_pc;
  logic [31:0]     load_instr;

  assign accept = !if_id_valid || !stall;
  assign target = redirect_pc & ALIGN_MASK;

  // Request is purely a function of state so addr/req never move while
  // waiting for an ack; reset kills it immediately.
  assign imem_req  = !rst && (state != HOLD);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      redir_pc   <= '0;
      hold_pc    <= '0;
      hold_instr <= NOP_INSTR;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      redir_pc   <= redir_pc_nxt;
      hold_pc    <= hold_pc_nxt;
      hold_instr <= hold_instr_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    redir_pc_nxt   = redir_pc;
    hold_pc_nxt    = hold_pc;
    hold_instr_nxt = hold_instr;
    load           = 1'b0;
    load_pc        = pc;
    load_instr     = imem_rdata;

    unique case (state)
      FETCH: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_nxt = target;
          end else if (accept) begin
            load   = 1'b1;
            pc_nxt = pc + PC_STEP;
          end else begin
            hold_pc_nxt    = pc;
            hold_instr_nxt = imem_rdata;
            pc_nxt         = pc + PC_STEP;
            state_nxt      = HOLD;
          end
        end else if (redirect) begin
          // Cannot retract the request, so remember where to go once it lands.
          redir_pc_nxt = target;
          state_nxt    = DROP;
        end
      end

      DROP: begin
        if (redirect) begin
          redir_pc_nxt = target;
        end
        if (imem_ack) begin
          // Latest redirect wins, including one arriving with the ack.
          pc_nxt    = redirect ? target : redir_pc;
          state_nxt = FETCH;
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_nxt    = target;
          state_nxt = FETCH;
        end else if (accept) begin
          load       = 1'b1;
          load_pc    = hold_pc;
          load_instr = hold_instr;
          state_nxt  = FETCH;
        end
      end

      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect),
    .load       (load),
    .hold       (stall),
    .load_pc    (load_pc),
    .load_instr (load_instr),
    .valid      (if_id_valid),
    .pc         (if_id_pc),
    .instr      (if_id_instr)
  );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fetch_stage                                                  |
// | Purpose  : Self-checking bench for fetch_stage. A queue-based model of     |
// |            the fetch stream is compared against the DUT every cycle, and   |
// |            directed scenarios pin specific cycle-level expectations.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        if_id_valid;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_id_valid (if_id_valid),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Staged stimulus, applied at the next negedge by tick().
  logic        rst_v = 1'b1;
  logic        stall_v = 1'b0;
  logic        redir_v = 1'b0;
  logic [63:0] rpc_v = '0;

  // Memory responder: ack arrives on the mem_lat-th cycle of a request.
  int mem_lat = 1;
  int wait_cnt = 0;

  // Behavioural model: fetched-but-undelivered words sit in a queue; while
  // that queue is non-empty no new fetch is issued.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc = '0;
  logic [63:0] m_redir = '0;
  bit          m_disc = 0;
  bit          m_v = 0;
  logic [63:0] m_ipc = '0;
  logic [31:0] m_iinstr = NOP;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [63:0] tgt;
    bit          req;
    bit          acc;
    ent_t        e;
    if (rst) begin
      mq.delete();
      m_pc     = 64'h0;
      m_disc   = 0;
      m_v      = 0;
      m_ipc    = 64'h0;
      m_iinstr = NOP;
    end else begin
      tgt = {redirect_pc[63:2], 2'b00};
      req = (mq.size() == 0);
      acc = !m_v || !stall;
      if (req && imem_ack) begin
        if (m_disc || redirect) begin
          m_pc   = redirect ? tgt : m_redir;
          m_disc = 0;
        end else begin
          e.pc    = m_pc;
          e.instr = imem_rdata;
          mq.push_back(e);
          m_pc = m_pc + 64'd4;
        end
      end else if (req && redirect) begin
        m_disc  = 1;
        m_redir = tgt;
      end else if (!req && redirect) begin
        mq.delete();
        m_pc = tgt;
      end
      if (redirect) begin
        m_v      = 0;
        m_iinstr = NOP;
      end else if (acc && mq.size() > 0) begin
        e        = mq.pop_front();
        m_v      = 1;
        m_ipc    = e.pc;
        m_iinstr = e.instr;
      end else if (!(m_v && stall)) begin
        m_v      = 0;
        m_iinstr = NOP;
      end
    end
  endtask

  task automatic compare();
    bit e_req;
    e_req = !rst && (mq.size() == 0);
    chk("imem_req", imem_req, e_req);
    if (e_req) chk("imem_addr", imem_addr, m_pc);
    chk("if_id_valid", if_id_valid, m_v);
    if (m_v) chk("if_id_pc", if_id_pc, m_ipc);
    chk("if_id_instr", if_id_instr, m_v ? m_iinstr : NOP);
  endtask

  // One clock: model consumes the inputs of the ending cycle, then the new
  // cycle's inputs are applied, outputs checked and memory answers.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    rst         = rst_v;
    stall       = stall_v;
    redirect    = redir_v;
    redirect_pc = rpc_v;
    #1;
    compare();
    if (imem_req) begin
      imem_ack   = (wait_cnt + 1 >= mem_lat);
      imem_rdata = imem_addr[31:0];
    end else begin
      imem_ack = 1'b0;
    end
    if (rst) wait_cnt = 0;
    else if (imem_req) wait_cnt = imem_ack ? 0 : wait_cnt + 1;
  endtask

  task automatic do_reset();
    rst_v = 1'b1; stall_v = 1'b0; redir_v = 1'b0;
    tick();
    tick();
    rst_v = 1'b0;
  endtask

  // Advance until imem_addr shows 'a' with req high; expiry is a failure.
  task automatic wait_addr(input logic [63:0] a, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (imem_req && imem_addr == a) break;
      tick();
    end
    chk("wait_addr", imem_addr, a);
  endtask

  logic [63:0] p;
  logic [15:0] stall_pat;

  initial begin
    // 1: reset then free-running stream
    mem_lat = 1;
    do_reset();
    chk("rst_valid", if_id_valid, 1'b0);
    chk("rst_pc", if_id_pc, 64'h0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_req", imem_req, 1'b0);
    tick();
    chk("t1_req", imem_req, 1'b1);
    chk("t1_addr0", imem_addr, 64'h0);
    chk("t1_novalid", if_id_valid, 1'b0);
    tick(); chk("t1_pc0", if_id_pc, 64'h0); chk("t1_v0", if_id_valid, 1'b1);
    tick(); chk("t1_pc4", if_id_pc, 64'h4);
    tick(); chk("t1_pc8", if_id_pc, 64'h8);
    tick(); chk("t1_pcC", if_id_pc, 64'hC); chk("t1_instrC", if_id_instr, 32'hC);

    // 2: stall for 3 cycles mid-stream
    stall_v = 1'b1;
    tick(); p = if_id_pc;
    tick(); chk("t2_hold_req", imem_req, 1'b0); chk("t2_hold_pc", if_id_pc, p);
    tick(); chk("t2_hold_req2", imem_req, 1'b0);
    stall_v = 1'b0;
    tick(); chk("t2_rel_pc", if_id_pc, p);
    tick(); chk("t2_next", if_id_pc, p + 64'd4); chk("t2_next_v", if_id_valid, 1'b1);
    tick(); chk("t2_next2", if_id_pc, p + 64'd8);

    // 3: slow memory, redirect one cycle into the request for 0x8
    mem_lat = 3;
    do_reset();
    tick();
    wait_addr(64'h8, 40);
    redir_v = 1'b1; rpc_v = 64'h100;
    tick(); chk("t3_addr_hold", imem_addr, 64'h8);
    redir_v = 1'b0;
    tick(); chk("t3_addr_hold2", imem_addr, 64'h8); chk("t3_req", imem_req, 1'b1);
    chk("t3_novalid", if_id_valid, 1'b0);
    tick(); chk("t3_new_addr", imem_addr, 64'h100); chk("t3_novalid2", if_id_valid, 1'b0);

    // 4: redirect coincident with ack for 0x10
    mem_lat = 1;
    do_reset();
    tick();
    wait_addr(64'hC, 20);
    redir_v = 1'b1; rpc_v = 64'h40;
    tick(); chk("t4_addr10", imem_addr, 64'h10);
    redir_v = 1'b0;
    tick(); chk("t4_addr40", imem_addr, 64'h40); chk("t4_flush", if_id_valid, 1'b0);
    tick(); chk("t4_pc40", if_id_pc, 64'h40); chk("t4_v40", if_id_valid, 1'b1);

    // 5: redirect while stalled with a live entry
    stall_v = 1'b1;
    tick(); chk("t5_pre_valid", if_id_valid, 1'b1);
    redir_v = 1'b1; rpc_v = 64'h200;
    tick();
    redir_v = 1'b0; stall_v = 1'b0;
    tick(); chk("t5_valid", if_id_valid, 1'b0); chk("t5_instr", if_id_instr, NOP);
    tick(); chk("t5_addr", imem_addr, 64'h204);

    // PC wraps and redirect target low bits are ignored
    redir_v = 1'b1; rpc_v = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redir_v = 1'b0;
    tick(); chk("wrap_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick(); chk("wrap_zero", imem_addr, 64'h0);
    tick(); chk("wrap_pc", if_id_pc, 64'h0);

    // Stall pattern with 2-cycle memory; model checks every cycle
    mem_lat = 2;
    stall_pat = 16'b0110_1110_0010_1101;
    for (int i = 0; i < 48; i++) begin
      stall_v = stall_pat[i % 16];
      tick();
    end
    stall_v = 1'b0;
    mem_lat = 1;
    for (int i = 0; i < 32; i++) begin
      stall_v = stall_pat[(i * 3) % 16];
      tick();
    end
    stall_v = 1'b0;

    // 6: reset while a stale request is being dropped
    mem_lat = 3;
    do_reset();
    tick();
    redir_v = 1'b1; rpc_v = 64'h80;
    tick();
    redir_v = 1'b0; rst_v = 1'b1;
    tick(); chk("t6_req_rst", imem_req, 1'b0);
    rst_v = 1'b0;
    tick();
    chk("t6_req", imem_req, 1'b1);
    chk("t6_addr", imem_addr, 64'h0);
    chk("t6_valid", if_id_valid, 1'b0);
    chk("t6_pc", if_id_pc, 64'h0);
    chk("t6_instr", if_id_instr, NOP);
    for (int i = 0; i < 8; i++) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
